// File: rtl/controle_multiciclo_pkg.sv
// -----------------------------------------------------------------------------
// controle_multiciclo_pkg
// Shared constants for the MIPS-subset control units (multi-cycle FSM and the
// single-cycle decoder): opcodes, the JR funct code, FSM state encodings, and
// the encodings of pc_fonte, c_reg_destino and c_ALUOp.
// No ports (package).
// -----------------------------------------------------------------------------
package controle_multiciclo_pkg;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // funct, IR[5:0], that turns an R-type into JR
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // FSM states
    localparam logic [2:0] ST_BUSCA      = 3'b000;
    localparam logic [2:0] ST_DECODIFICA = 3'b001;
    localparam logic [2:0] ST_EXECUTA    = 3'b010;
    localparam logic [2:0] ST_MEMORIA    = 3'b011;
    localparam logic [2:0] ST_ESCRITA    = 3'b100;

    // PC source mux
    localparam logic [1:0] PC_MAIS4  = 2'b00;
    localparam logic [1:0] PC_DESVIO = 2'b01;
    localparam logic [1:0] PC_SALTO  = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    // Destination register select
    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_SOMA  = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // True for every opcode the control unit knows how to sequence.
    function automatic logic opcode_conhecido(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_LW, OP_SW: opcode_conhecido = 1'b1;
            default:               opcode_conhecido = 1'b0;
        endcase
    endfunction

    // JR is an R-type whose funct field selects a register jump.
    function automatic logic eh_jr(input logic [5:0] op, input logic [5:0] fn);
        eh_jr = (op == OP_RTYPE) && (fn == FUNCT_JR);
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// -----------------------------------------------------------------------------
// controle_multiciclo_if
// Shared-memory handshake between the multi-cycle control unit and memory.
//   mem_req       : access request, held until mem_ready
//   mem_escrever  : 1 = write, 0 = read
//   mem_fonte_end : address select, 0 = PC, 1 = ALU result
//   mem_ready     : acknowledge; completes the access in the same cycle
// Modports: master (control unit), slave (memory side).
// -----------------------------------------------------------------------------
interface controle_multiciclo_if;

    logic mem_req;
    logic mem_escrever;
    logic mem_fonte_end;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_escrever,
        output mem_fonte_end,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_escrever,
        input  mem_fonte_end,
        output mem_ready
    );

endinterface

// File: rtl/controle_multiciclo.sv
// -----------------------------------------------------------------------------
// controle_multiciclo
// Multi-cycle control FSM for a MIPS subset (R-type, JR, J, JAL, BEQ, BNE,
// ADDI, LW, SW) sharing one memory for instructions and data.
// Ports:
//   clock, reset      : single clock, synchronous active-high reset
//   habilitar         : allows a new fetch to start (looked at in BUSCA only)
//   opcode, funct     : IR[31:26], IR[5:0]
//   zero              : ALU zero flag, used by BEQ/BNE in EXECUTA
//   mem               : memory handshake (master side)
//   ir_escrever, pc_escrever : one-cycle load strobes
//   pc_fonte          : PC mux select
//   c_ALUOp, c_fonte_ula, c_memtoreg, c_escrever_reg, c_reg_destino :
//                       datapath controls, same encodings as single-cycle
//   estado            : current FSM state
//   invalido          : one-cycle pulse on an unknown opcode
// All outputs are combinational from the state and current inputs, and all
// are forced to zero while reset is high.
// -----------------------------------------------------------------------------
module controle_multiciclo (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  habilitar,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    controle_multiciclo_if.master mem,
    output logic                  ir_escrever,
    output logic                  pc_escrever,
    output logic [1:0]            pc_fonte,
    output logic [1:0]            c_ALUOp,
    output logic                  c_fonte_ula,
    output logic                  c_memtoreg,
    output logic                  c_escrever_reg,
    output logic [1:0]            c_reg_destino,
    output logic [2:0]            estado,
    output logic                  invalido
);

    import controle_multiciclo_pkg::*;

    logic [2:0] estado_q;
    logic [2:0] estado_d;

    always_comb begin
        estado_d          = estado_q;
        estado            = estado_q;
        mem.mem_req       = 1'b0;
        mem.mem_escrever  = 1'b0;
        mem.mem_fonte_end = 1'b0;
        ir_escrever       = 1'b0;
        pc_escrever       = 1'b0;
        pc_fonte          = PC_MAIS4;
        c_ALUOp           = ALUOP_SOMA;
        c_fonte_ula       = 1'b0;
        c_memtoreg        = 1'b0;
        c_escrever_reg    = 1'b0;
        c_reg_destino     = REG_DST_RT;
        invalido          = 1'b0;

        if (reset) begin
            // Everything quiet, including the reported state, while in reset.
            estado   = ST_BUSCA;
            estado_d = ST_BUSCA;
        end else begin
            case (estado_q)
                ST_BUSCA: begin
                    // mem_ready only counts while a fetch is actually requested.
                    mem.mem_req = habilitar;
                    if (habilitar && mem.mem_ready) begin
                        ir_escrever = 1'b1;
                        pc_escrever = 1'b1;
                        pc_fonte    = PC_MAIS4;
                        estado_d    = ST_DECODIFICA;
                    end
                end

                ST_DECODIFICA: begin
                    if (opcode == OP_J) begin
                        pc_escrever = 1'b1;
                        pc_fonte    = PC_SALTO;
                        estado_d    = ST_BUSCA;
                    end else if (opcode == OP_JAL) begin
                        // Link register written here; PC+4 is already in PC.
                        pc_escrever    = 1'b1;
                        pc_fonte       = PC_SALTO;
                        c_escrever_reg = 1'b1;
                        c_reg_destino  = REG_DST_RA;
                        estado_d       = ST_BUSCA;
                    end else if (!opcode_conhecido(opcode)) begin
                        invalido = 1'b1;
                        estado_d = ST_BUSCA;
                    end else begin
                        estado_d = ST_EXECUTA;
                    end
                end

                ST_EXECUTA: begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (eh_jr(opcode, funct)) begin
                                pc_escrever = 1'b1;
                                pc_fonte    = PC_REG;
                                estado_d    = ST_BUSCA;
                            end else begin
                                c_ALUOp     = ALUOP_FUNCT;
                                c_fonte_ula = 1'b0;
                                estado_d    = ST_ESCRITA;
                            end
                        end
                        OP_ADDI: begin
                            c_ALUOp     = ALUOP_SOMA;
                            c_fonte_ula = 1'b1;
                            estado_d    = ST_ESCRITA;
                        end
                        OP_LW, OP_SW: begin
                            // ALU computes the effective address for MEMORIA.
                            c_ALUOp     = ALUOP_SOMA;
                            c_fonte_ula = 1'b1;
                            estado_d    = ST_MEMORIA;
                        end
                        OP_BEQ, OP_BNE: begin
                            c_ALUOp     = ALUOP_SUB;
                            c_fonte_ula = 1'b0;
                            pc_fonte    = PC_DESVIO;
                            pc_escrever = (opcode == OP_BEQ) ? zero : ~zero;
                            estado_d    = ST_BUSCA;
                        end
                        default: begin
                            estado_d = ST_BUSCA;
                        end
                    endcase
                end

                ST_MEMORIA: begin
                    mem.mem_req       = 1'b1;
                    mem.mem_fonte_end = 1'b1;
                    mem.mem_escrever  = (opcode == OP_SW);
                    if (mem.mem_ready) begin
                        estado_d = (opcode == OP_SW) ? ST_BUSCA : ST_ESCRITA;
                    end
                end

                ST_ESCRITA: begin
                    case (opcode)
                        OP_RTYPE: begin
                            c_escrever_reg = 1'b1;
                            c_reg_destino  = REG_DST_RD;
                            c_memtoreg     = 1'b0;
                        end
                        OP_ADDI: begin
                            c_escrever_reg = 1'b1;
                            c_reg_destino  = REG_DST_RT;
                            c_memtoreg     = 1'b0;
                        end
                        OP_LW: begin
                            c_escrever_reg = 1'b1;
                            c_reg_destino  = REG_DST_RT;
                            c_memtoreg     = 1'b1;
                        end
                        default: begin
                            c_escrever_reg = 1'b0;
                        end
                    endcase
                    estado_d = ST_BUSCA;
                end

                default: begin
                    // Unused encodings recover to a fetch.
                    estado_d = ST_BUSCA;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ST_BUSCA;
        end else begin
            estado_q <= estado_d;
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_controle_multiciclo
// Builds, per instruction, the expected per-cycle output trace from the
// instruction's phase list (fetch, decode, execute, memory, write-back), then
// drives the DUT cycle by cycle while one compare process checks every cycle.
// -----------------------------------------------------------------------------
module tb_controle_multiciclo;

    // Opcodes and funct as plain literals, independent of the RTL package.
    localparam logic [5:0] T_R    = 6'd0;
    localparam logic [5:0] T_J    = 6'd2;
    localparam logic [5:0] T_JAL  = 6'd3;
    localparam logic [5:0] T_BEQ  = 6'd4;
    localparam logic [5:0] T_BNE  = 6'd5;
    localparam logic [5:0] T_ADDI = 6'd8;
    localparam logic [5:0] T_LW   = 6'd35;
    localparam logic [5:0] T_SW   = 6'd43;
    localparam logic [5:0] T_FJR  = 6'd8;

    localparam logic [2:0] E_B = 3'd0;
    localparam logic [2:0] E_D = 3'd1;
    localparam logic [2:0] E_E = 3'd2;
    localparam logic [2:0] E_M = 3'd3;
    localparam logic [2:0] E_W = 3'd4;

    typedef struct packed {
        logic [2:0] est;
        logic       req;
        logic       wr;
        logic       fe;
        logic       ir;
        logic       pcw;
        logic [1:0] pcf;
        logic [1:0] alu;
        logic       fu;
        logic       m2r;
        logic       erg;
        logic [1:0] dst;
        logic       inv;
    } out_t;

    typedef struct {
        logic       rst;
        logic       hab;
        logic       rdy;
        logic       z;
        logic [5:0] op;
        logic [5:0] fn;
        out_t       exp;
    } ent_t;

    logic       clock;
    logic       reset;
    logic       habilitar;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ir_escrever, pc_escrever;
    logic [1:0] pc_fonte, c_ALUOp, c_reg_destino;
    logic       c_fonte_ula, c_memtoreg, c_escrever_reg, invalido;
    logic [2:0] estado;

    controle_multiciclo_if mem_bus ();

    controle_multiciclo dut (
        .clock          (clock),
        .reset          (reset),
        .habilitar      (habilitar),
        .opcode         (opcode),
        .funct          (funct),
        .zero           (zero),
        .mem            (mem_bus),
        .ir_escrever    (ir_escrever),
        .pc_escrever    (pc_escrever),
        .pc_fonte       (pc_fonte),
        .c_ALUOp        (c_ALUOp),
        .c_fonte_ula    (c_fonte_ula),
        .c_memtoreg     (c_memtoreg),
        .c_escrever_reg (c_escrever_reg),
        .c_reg_destino  (c_reg_destino),
        .estado         (estado),
        .invalido       (invalido)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    out_t dut_o;
    assign dut_o = {estado, mem_bus.mem_req, mem_bus.mem_escrever, mem_bus.mem_fonte_end,
                    ir_escrever, pc_escrever, pc_fonte, c_ALUOp, c_fonte_ula,
                    c_memtoreg, c_escrever_reg, c_reg_destino, invalido};

    ent_t plan[$];
    out_t chk[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    function automatic logic rb();
        return ($urandom_range(0, 1) == 1);
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic known_op(input logic [5:0] op);
        return op inside {T_R, T_J, T_JAL, T_BEQ, T_BNE, T_ADDI, T_LW, T_SW};
    endfunction

    task automatic add(input logic rst, input logic hab, input logic rdy, input logic z,
                       input logic [5:0] op, input logic [5:0] fn, input out_t exp);
        ent_t e;
        e.rst = rst; e.hab = hab; e.rdy = rdy; e.z = z;
        e.op = op; e.fn = fn; e.exp = exp;
        plan.push_back(e);
    endtask

    task automatic add_idle();
        add(1'b0, 1'b0, rb(), rb(), r6(), r6(), '0);
    endtask

    task automatic add_reset();
        add(1'b1, rb(), rb(), rb(), r6(), r6(), '0);
    endtask

    // Expected trace of one instruction: fw fetch wait cycles, mw memory waits.
    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int fw, input int mw);
        out_t o;
        // fetch
        for (int k = 0; k < fw; k++) begin
            o = '0; o.est = E_B; o.req = 1'b1;
            add(1'b0, 1'b1, 1'b0, rb(), r6(), r6(), o);
        end
        o = '0; o.est = E_B; o.req = 1'b1; o.ir = 1'b1; o.pcw = 1'b1; o.pcf = 2'b00;
        add(1'b0, 1'b1, 1'b1, rb(), r6(), r6(), o);
        // decode
        o = '0; o.est = E_D;
        if (op == T_J) begin
            o.pcw = 1'b1; o.pcf = 2'b10;
            add(1'b0, rb(), rb(), rb(), op, fn, o);
            return;
        end
        if (op == T_JAL) begin
            o.pcw = 1'b1; o.pcf = 2'b10; o.erg = 1'b1; o.dst = 2'b10;
            add(1'b0, rb(), rb(), rb(), op, fn, o);
            return;
        end
        if (!known_op(op)) begin
            o.inv = 1'b1;
            add(1'b0, rb(), rb(), rb(), op, fn, o);
            return;
        end
        add(1'b0, rb(), rb(), rb(), op, fn, o);
        // execute
        o = '0; o.est = E_E;
        if (op == T_R && fn == T_FJR) begin
            o.pcw = 1'b1; o.pcf = 2'b11;
            add(1'b0, rb(), rb(), z, op, fn, o);
            return;
        end
        if (op == T_BEQ || op == T_BNE) begin
            o.alu = 2'b01; o.pcf = 2'b01;
            o.pcw = (op == T_BEQ) ? z : ~z;
            add(1'b0, rb(), rb(), z, op, fn, o);
            return;
        end
        if (op == T_R) begin
            o.alu = 2'b10; o.fu = 1'b0;
        end else begin
            o.alu = 2'b00; o.fu = 1'b1;
        end
        add(1'b0, rb(), rb(), z, op, fn, o);
        // memory
        if (op == T_LW || op == T_SW) begin
            o = '0; o.est = E_M; o.req = 1'b1; o.fe = 1'b1; o.wr = (op == T_SW);
            for (int k = 0; k < mw; k++) add(1'b0, rb(), 1'b0, rb(), op, fn, o);
            add(1'b0, rb(), 1'b1, rb(), op, fn, o);
            if (op == T_SW) return;
        end
        // write-back
        o = '0; o.est = E_W; o.erg = 1'b1;
        o.dst = (op == T_R) ? 2'b01 : 2'b00;
        o.m2r = (op == T_LW);
        add(1'b0, rb(), rb(), rb(), op, fn, o);
    endtask

    task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL pin %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic run_plan();
        foreach (plan[i]) begin
            reset             = plan[i].rst;
            habilitar         = plan[i].hab;
            mem_bus.mem_ready = plan[i].rdy;
            zero              = plan[i].z;
            opcode            = plan[i].op;
            funct             = plan[i].fn;
            chk.push_back(plan[i].exp);
            @(posedge clock);
            #1;
        end
        plan.delete();
    endtask

    // Single per-cycle compare process.
    initial begin
        out_t e;
        forever begin
            @(negedge clock);
            cycle++;
            if (chk.size() > 0) begin
                e = chk.pop_front();
                checks++;
                if (dut_o !== e) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: got %05h want %05h (estado got %0d want %0d)",
                             cycle, dut_o, e, dut_o.est, e.est);
                end
            end
        end
    end

    initial begin
        int s, cnt, n, len, sel;
        logic [5:0] op, fn;
        reset = 1'b1; habilitar = 1'b0; zero = 1'b0;
        opcode = '0; funct = '0; mem_bus.mem_ready = 1'b0;
        @(posedge clock);
        #1;

        add_reset();
        add_reset();

        // ADD with immediate memory
        s = plan.size();
        plan_instr(T_R, 6'b100000, 1'b0, 0, 0);
        pin("add_len", plan.size() - s, 4);
        pin("add_escrita", plan[s + 3].exp, {3'b100, 5'b00000, 2'b00, 2'b00, 3'b001, 2'b01, 1'b0});
        pin("add_executa", plan[s + 2].exp, {3'b010, 5'b00000, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0});
        pin("busca_ok", plan[s].exp, {3'b000, 5'b10011, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0});

        // LW with three memory wait cycles
        s = plan.size();
        plan_instr(T_LW, r6(), 1'b0, 0, 3);
        pin("lw_len", plan.size() - s, 8);
        cnt = 0;
        for (int i = s; i < plan.size(); i++) if (plan[i].exp.req && plan[i].exp.est == E_M) cnt++;
        pin("lw_mem_ciclos", cnt, 4);
        pin("lw_memoria", plan[s + 3].exp, {3'b011, 5'b10100, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0});
        pin("lw_escrita", plan[s + 7].exp, {3'b100, 5'b00000, 2'b00, 2'b00, 3'b011, 2'b00, 1'b0});

        // BEQ taken / not taken
        s = plan.size();
        plan_instr(T_BEQ, r6(), 1'b1, 0, 0);
        pin("beq1_len", plan.size() - s, 3);
        pin("beq1_executa", plan[s + 2].exp, {3'b010, 5'b00001, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0});
        s = plan.size();
        plan_instr(T_BEQ, r6(), 1'b0, 0, 0);
        pin("beq0_executa", plan[s + 2].exp, {3'b010, 5'b00000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0});

        // JAL and an unknown opcode
        s = plan.size();
        plan_instr(T_JAL, r6(), 1'b0, 0, 0);
        pin("jal_len", plan.size() - s, 2);
        pin("jal_decod", plan[s + 1].exp, {3'b001, 5'b00001, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0});
        s = plan.size();
        plan_instr(6'b111111, r6(), 1'b0, 0, 0);
        pin("inv_len", plan.size() - s, 2);
        pin("inv_decod", plan[s + 1].exp, {3'b001, 5'b00000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1});

        // remaining latencies
        s = plan.size(); plan_instr(T_J, r6(), 1'b0, 0, 0);    pin("j_len", plan.size() - s, 2);
        s = plan.size(); plan_instr(T_R, T_FJR, 1'b0, 0, 0);   pin("jr_len", plan.size() - s, 3);
        s = plan.size(); plan_instr(T_BNE, r6(), 1'b1, 0, 0);  pin("bne_len", plan.size() - s, 3);
        s = plan.size(); plan_instr(T_ADDI, r6(), 1'b0, 0, 0); pin("addi_len", plan.size() - s, 4);
        s = plan.size(); plan_instr(T_SW, r6(), 1'b0, 0, 0);   pin("sw_len", plan.size() - s, 4);

        // SW reset mid-MEMORIA, then habilitar low
        s = plan.size();
        plan_instr(T_SW, r6(), 1'b0, 0, 2);
        pin("sw_memoria", plan[s + 3].exp, {3'b011, 5'b11100, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0});
        while (plan.size() > s + 4) void'(plan.pop_back());
        add_reset();
        for (int k = 0; k < 3; k++) add_idle();

        run_plan();

        // randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                for (int k = 0; k < $urandom_range(1, 3); k++) add_idle();
            end
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = T_R;
                1: op = T_J;
                2: op = T_JAL;
                3: op = T_BEQ;
                4: op = T_BNE;
                5: op = T_ADDI;
                6: op = T_LW;
                7: op = T_SW;
                8: op = T_R;
                default: op = r6();
            endcase
            fn = (sel == 8) ? T_FJR : r6();
            s = plan.size();
            plan_instr(op, fn, rb(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                       $urandom_range(0, 3));
            len = plan.size() - s;
            if ($urandom_range(0, 9) == 0 && len >= 2) begin
                n = $urandom_range(1, len - 1);
                while (plan.size() > s + n) void'(plan.pop_back());
                add_reset();
            end
        end
        run_plan();

        repeat (2) @(negedge clock);
        checks++;
        if (chk.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", chk.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
Parameters: none.
REQ-001 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port habilitar, input, 1, permits start of a new instruction fetch.
REQ-004 SHALL have port opcode, input, 6, IR[31:26]; stable from DECODIFICA until return to BUSCA.
REQ-005 SHALL have port funct, input, 6, IR[5:0]; funct 001000 with opcode 000000 is JR.
REQ-006 SHALL have port zero, input, 1, ALU zero flag, sampled in EXECUTA.
REQ-007 SHALL have port mem_ready, input, 1, shared memory acknowledge; completes the current access in the same cycle.
REQ-008 SHALL have port mem_req, output, 1, shared memory request; held until mem_ready.
REQ-009 SHALL have port mem_escrever, output, 1, 1=write, 0=read.
REQ-010 SHALL have port mem_fonte_end, output, 1, address select: 0=PC, 1=ALU result.
REQ-011 SHALL have ports ir_escrever and pc_escrever, outputs, 1 each, single-cycle load pulses.
REQ-012 SHALL have port pc_fonte, output, 2, PC mux: 00 PC+4, 01 branch target, 10 jump target, 11 register (JR).
REQ-013 SHALL have ports c_ALUOp (2), c_fonte_ula (1), c_memtoreg (1), c_escrever_reg (1), outputs; encodings identical to the single-cycle decoder.
REQ-014 SHALL have port c_reg_destino, output, 2, write register: 00 rt, 01 rd, 10 $31.
REQ-015 SHALL have ports estado (3) and invalido (1), outputs, current state and one-cycle unknown-opcode pulse.

Function
REQ-016 SHALL implement states BUSCA=000, DECODIFICA=001, EXECUTA=010, MEMORIA=011, ESCRITA=100.
REQ-017 BUSCA: mem_req=habilitar, mem_fonte_end=0, mem_escrever=0; on mem_ready=1, pulse ir_escrever and pc_escrever (pc_fonte=00) and go to DECODIFICA; otherwise stay.
REQ-018 DECODIFICA: no outputs active; J -> pc_escrever=1, pc_fonte=10, next BUSCA; JAL -> same plus c_escrever_reg=1, c_reg_destino=10, next BUSCA; unknown opcode -> invalido=1, next BUSCA; all others -> EXECUTA.
REQ-019 EXECUTA, R-type (not JR): c_ALUOp=10, c_fonte_ula=0, next ESCRITA.
REQ-020 EXECUTA, JR: pc_escrever=1, pc_fonte=11, next BUSCA, no register write.
REQ-021 EXECUTA, ADDI/LW/SW: c_ALUOp=00, c_fonte_ula=1; ADDI -> ESCRITA, LW/SW -> MEMORIA.
REQ-022 EXECUTA, BEQ/BNE: c_ALUOp=01, c_fonte_ula=0, pc_fonte=01; pc_escrever=zero (BEQ) or ~zero (BNE); next BUSCA.
REQ-023 MEMORIA: mem_req=1, mem_fonte_end=1, mem_escrever=1 for SW, 0 for LW; hold until mem_ready; then SW -> BUSCA, LW -> ESCRITA.
REQ-024 ESCRITA: c_escrever_reg=1 for one cycle; R-type c_reg_destino=01, c_memtoreg=0; ADDI 00/0; LW 00/1; next BUSCA.
REQ-025 Cycle counts with mem_ready immediate: J/JAL 2, BEQ/BNE/JR 3, R/ADDI/SW 4, LW 5; each memory wait cycle adds one.
REQ-026 habilitar SHALL be examined only in BUSCA; deassertion mid-instruction does not stall the current instruction.
REQ-027 mem_ready outside an active mem_req SHALL be ignored.
REQ-028 All outputs SHALL be combinational from estado, opcode, funct, zero, habilitar, mem_ready; no output is asserted outside the state listed for it.

Reset
REQ-029 reset=1 at a rising edge SHALL force estado=BUSCA; while reset=1 every output is 0, including mem_req.
REQ-030 Reset during MEMORIA or ESCRITA SHALL abandon the access/write; the first fetch request is issued the cycle after reset deasserts if habilitar=1.

Structure
REQ-031 Opcode constants, funct JR constant, state encodings and pc_fonte/c_reg_destino encodings SHALL live in a shared package used with the single-cycle decoder.
REQ-032 SHALL be a single module; no sub-module required.

Verification
REQ-033 ADD (op 000000, funct 100000), mem_ready=1 -> BUSCA, DECODIFICA, EXECUTA, ESCRITA; c_escrever_reg=1 with c_reg_destino=01 on cycle 4.
REQ-034 LW with mem_ready low 3 cycles in MEMORIA -> mem_req held 4 cycles, mem_escrever=0, then ESCRITA with c_memtoreg=1; 8 cycles total.
REQ-035 BEQ with zero=1 -> pc_escrever=1, pc_fonte=01 in EXECUTA; with zero=0 -> pc_escrever=0; both return to BUSCA after 3 cycles.
REQ-036 JAL -> 2 cycles, pc_fonte=10, c_escrever_reg=1, c_reg_destino=10 in DECODIFICA; opcode 111111 -> invalido pulse, back to BUSCA.
REQ-037 reset asserted mid-MEMORIA of SW -> next cycle estado=000, mem_req=0; habilitar=0 afterwards -> stays in BUSCA with mem_req=0.
